line_sched: RTL and testbench
=============================

# line_sched

Serial-line scheduler that shares one serial pattern-recognizer instance (single-bit `LINEA` in, single-bit `U` out) among several requesters. Each requester presents a parallel word. The scheduler grants requesters round-robin and shifts the granted word onto the line LSB-first. It then waits a drain window and counts recognizer `U` pulses. The count is returned with a one-cycle completion strobe. It sits between the block-level request logic and the recognizer FSM in the ITC99-style test designs.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `WIDTH`, 8: bits per word shifted onto the line (1..32).
- `DRAIN`, 2: idle cycles after the last bit before completion (0..7).
- `CW`, 4: width of the hit counter.
- `clock` in 1: the only clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `req` in NREQ: level request per requester; must be held until `done`.
- `wdata` in NREQ*WIDTH: word for requester i at `[i*WIDTH +: WIDTH]`; sampled only at grant.
- `gnt` out NREQ: one-hot grant, registered.
- `linea` out 1: drives recognizer `LINEA`, registered.
- `u` in 1: recognizer output `U`.
- `busy` out 1: high in SHIFT, DRAIN and DONE.
- `done` out 1: one-cycle completion strobe.
- `hits` out CW: number of cycles `u`=1 during the transaction; valid while `done`=1 and held until the next grant.

## Operation
- States: IDLE, SHIFT, DRAIN, DONE. State is one register; there are no other modes.
- Reset values:
  - state IDLE; `gnt`=0, `linea`=0, `busy`=0, `done`=0, `hits`=0.
  - bit counter 0; round-robin pointer `last`=NREQ-1, so requester 0 wins first.
- IDLE, no requests: outputs hold; `linea`=0.
- IDLE, any `req` high:
  - Select the first asserted index searching `last+1, last+2, …` modulo NREQ.
  - Set `gnt[sel]`, load the shift register from `wdata[sel]` and clear the counter.
  - Drive `linea` = bit 0 and go to SHIFT.
- SHIFT:
  - Each cycle, add `u` to the counter, saturating at 2^CW−1.
  - Shift out the next bit. After WIDTH bits go to DRAIN, or straight to DONE if DRAIN=0.
- DRAIN: `linea`=0. Count `u` for DRAIN cycles, then go to DONE.
- DONE:
  - `done`=1 for exactly one cycle, `hits` = final count, `gnt` still asserted, `linea`=0.
  - Set `last`=sel and return to IDLE; `gnt` clears on that edge.
- `req` of non-granted requesters may change freely during a transaction. The granted requester's `req` is ignored after grant unless the abort feature is compiled in.
- A requester holding `req` after `done` is re-arbitrated normally. Round-robin guarantees other pending requesters are served first.
- `wdata` changes after grant have no effect.
- `reset` mid-transaction: the next cycle shows all reset values, with no `done`.
- `u` during IDLE and DONE is ignored.

## Timing
- Request sampled at edge k (IDLE) → `gnt` and `busy` high, `linea`=bit 0 in cycle k+1.
- Bit i is on `linea` in cycle k+1+i.
- `u` is sampled at the end of every SHIFT and DRAIN cycle, i.e. WIDTH+DRAIN samples. This captures the recognizer's registered response to the previous bit.
- `done` is high in cycle k+1+WIDTH+DRAIN.
- Earliest next grant edge is the end of the DONE cycle, so the new `gnt` appears in cycle k+2+WIDTH+DRAIN.
- Back-to-back throughput: one transaction per WIDTH+DRAIN+1 cycles.
- No combinational path from any input to any output.

## Configuration
- `LINE_SCHED_ABORT_EN` defined:
  - In SHIFT or DRAIN, the granted requester's `req`=0 at an edge moves to IDLE on that edge.
  - `gnt`=0 and `linea`=0, with no `done` pulse; `hits` holds its old value.
  - `last` is set to the aborted index.
- `LINE_SCHED_ABORT_EN` undefined: `req` is ignored after grant; every granted transaction completes with `done`.

## Test plan
- Reset then single request: `req`=4'b0001, `wdata[7:0]`=8'hA5, `u`=0 → `gnt`=0001 one cycle after request, `linea` sequence 1,0,1,0,0,1,0,1, then 0,0; `done` in cycle 11 after request edge; `hits`=0.
- Hit counting: bench drives `u`=1 on SHIFT cycles 2,3,7 and DRAIN cycle 1 → `hits`=4 at `done`. With `u` stuck 1 and CW=2 → `hits`=3 (saturated).
- Round-robin: `req`=4'b1111 held continuously → grant order 0,1,2,3,0. Each grant lasts 11 cycles with exactly one `done` per grant; `gnt` is never multi-hot.
- Fairness after hold: requester 2 keeps `req` high after `done` while requester 1 is pending → requester 1 is granted next.
- Mid-transaction reset: assert `reset` at SHIFT bit 3 → next cycle `gnt`=0, `linea`=0, `busy`=0, `hits`=0, no `done`. A subsequent `req`=4'b1000 is granted, pointer reset, with normal completion.
- Abort (`LINE_SCHED_ABORT_EN`): drop the granted `req` at bit 5 → IDLE next cycle, no `done`, `hits` unchanged. Without the macro, the same stimulus completes with `done`.

Source files
------------

// File: rtl/line_sched.sv
// Round-robin scheduler that serialises one requester's word onto a shared
// recognizer line and counts its U pulses. Optional abort: LINE_SCHED_ABORT_EN.
module line_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DRAIN = 2,
    parameter int CW    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic                  linea,
    input  logic                  u,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         hits
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(WIDTH + DRAIN + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);
    localparam logic [BW-1:0] LAST_DRAIN = BW'((DRAIN > 0) ? DRAIN - 1 : 0);
    localparam logic [LW-1:0] LAST_INIT  = LW'(NREQ - 1);

    logic [1:0]       state;
    logic [LW-1:0]    last;
    logic [LW-1:0]    sel;
    logic [BW-1:0]    bcnt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;

    logic [LW-1:0]    base;
    logic [LW-1:0]    pick;
    logic [WIDTH-1:0] word;
    logic             any;
    logic             start;
    logic [CW-1:0]    cnt_nxt;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] c, input logic b);
        return (b && (c != '1)) ? c + CW'(1) : c;
    endfunction

    // In DONE the pointer has not been written yet, so search from the current grant.
    assign base    = (state == S_DONE) ? sel : last;
    assign start   = any && ((state == S_IDLE) || (state == S_DONE));
    assign cnt_nxt = sat_add(cnt, u);

    always_comb begin
        int idx;
        idx  = 0;
        any  = 1'b0;
        pick = '0;
        word = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(base) + i) % NREQ;
            if (!any && req[idx]) begin
                any  = 1'b1;
                pick = LW'(idx);
                word = wdata[idx*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register sees the pre-edge values of its neighbours.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            last  <= LAST_INIT;
            sel   <= '0;
            bcnt  <= '0;
            shreg <= '0;
            cnt   <= '0;
            gnt   <= '0;
            linea <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hits  <= '0;
        end else begin
            done <= 1'b0;
            if (state == S_DONE) last <= sel;

            if (start) begin
                state <= S_SHIFT;
                gnt   <= NREQ'(1) << pick;
                sel   <= pick;
                linea <= word[0];
                shreg <= word >> 1;
                cnt   <= '0;
                bcnt  <= '0;
                busy  <= 1'b1;
            end
`ifdef LINE_SCHED_ABORT_EN
            else if (((state == S_SHIFT) || (state == S_DRAIN)) && !req[sel]) begin
                state <= S_IDLE;
                gnt   <= '0;
                linea <= 1'b0;
                busy  <= 1'b0;
                last  <= sel;
            end
`endif
            else begin
                case (state)
                    S_SHIFT: begin
                        cnt   <= cnt_nxt;
                        bcnt  <= bcnt + BW'(1);
                        linea <= shreg[0];
                        shreg <= shreg >> 1;
                        if (bcnt == LAST_BIT) begin
                            bcnt  <= '0;
                            linea <= 1'b0;
                            if (DRAIN == 0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                                hits  <= cnt_nxt;
                            end else begin
                                state <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        cnt  <= cnt_nxt;
                        bcnt <= bcnt + BW'(1);
                        if (bcnt == LAST_DRAIN) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            hits  <= cnt_nxt;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_line_sched.sv
// Scoreboard bench for line_sched: expected grant index and hit count are queued
// at grant time and compared when done is observed.
module tb_line_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DRAIN = 2;
    localparam int CW    = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req   = '0;
    logic [3:0]  req2  = '0;
    logic [31:0] wdata = '0;
    logic [31:0] wdata2 = '0;
    logic        u  = 1'b0;
    logic        u2 = 1'b0;
    logic [3:0]  gnt, gnt2;
    logic        linea, linea2, busy, busy2, done, done2;
    logic [3:0]  hits;
    logic [1:0]  hits2;

    typedef struct {
        int idx;
        int hits;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad = 0;
    int rr_last = 3;
    int last_hits = 0;

    line_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DRAIN(DRAIN), .CW(CW)) dut (
        .clock(clock), .reset(reset), .req(req), .wdata(wdata), .gnt(gnt),
        .linea(linea), .u(u), .busy(busy), .done(done), .hits(hits)
    );

    line_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .DRAIN(DRAIN), .CW(2)) dut2 (
        .clock(clock), .reset(reset), .req(req2), .wdata(wdata2), .gnt(gnt2),
        .linea(linea2), .u(u2), .busy(busy2), .done(done2), .hits(hits2)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int next_idx(int last, logic [3:0] r);
        for (int i = 1; i <= 4; i++) begin
            int k = (last + i) % 4;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    function automatic int sat(int n, int cw);
        int m = (1 << cw) - 1;
        return (n > m) ? m : n;
    endfunction

    function automatic int gnt_idx(logic [3:0] g);
        if (!$onehot(g)) return -1;
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (done === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req = '0; req2 = '0; u = 1'b0; u2 = 1'b0;
        tick(); tick();
        reset = 1'b0;
        total++; if (gnt !== 4'b0) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
        total++; if (linea !== 1'b0) begin bad++; $display("FAIL reset_linea got=%b want=0", linea); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (hits !== 4'd0) begin bad++; $display("FAIL reset_hits got=%0d want=0", hits); end
        tick();
        total++; if ({gnt, linea, busy} !== 6'b0) begin bad++; $display("FAIL idle_hold got=%b want=000000", {gnt, linea, busy}); end
        rr_last = 3;
    endtask

    task automatic test_single;
        logic [7:0] w;
        exp_t e;
        int ei;
        w = 8'hA5;
        wdata = $urandom();
        wdata[7:0] = w;
        req = 4'b0001; u = 1'b0;
        ei = next_idx(rr_last, req);
        sbq.push_back('{ei, 0});
        tick();
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b want=0001", gnt); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
        for (int i = 0; i < 8; i++) begin
            total++; if (linea !== w[i]) begin bad++; $display("FAIL single_bit%0d got=%b want=%b", i, linea, w[i]); end
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            total++; if ({linea, done} !== 2'b00) begin bad++; $display("FAIL single_drain%0d linea,done got=%b want=00", d, {linea, done}); end
            tick();
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL single_done_cycle11 got=%b want=1", done); end
        e = sbq.pop_front();
        total++; if (gnt_idx(gnt) !== e.idx) begin bad++; $display("FAIL single_sb_idx got=%0d want=%0d", gnt_idx(gnt), e.idx); end
        total++; if (hits !== 4'(e.hits)) begin bad++; $display("FAIL single_sb_hits got=%0d want=%0d", hits, e.hits); end
        rr_last = e.idx; last_hits = e.hits;
        req = '0;
        tick();
        total++; if ({gnt, busy, done} !== 6'b0) begin bad++; $display("FAIL single_after got=%b want=000000", {gnt, busy, done}); end
    endtask

    task automatic test_hits;
        logic [9:0] pat;
        exp_t e;
        int ei;
        pat = 10'b0101000110;
        wdata = $urandom();
        req = 4'b0010;
        ei = next_idx(rr_last, req);
        sbq.push_back('{ei, sat($countones(pat), CW)});
        tick();
        for (int c = 0; c < 10; c++) begin
            u = pat[c];
            tick();
        end
        u = 1'b1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL hits_done got=%b want=1", done); end
        e = sbq.pop_front();
        total++; if (gnt_idx(gnt) !== e.idx) begin bad++; $display("FAIL hits_sb_idx got=%0d want=%0d", gnt_idx(gnt), e.idx); end
        total++; if (hits !== 4'(e.hits)) begin bad++; $display("FAIL hits_sb_hits got=%0d want=%0d", hits, e.hits); end
        rr_last = e.idx; last_hits = e.hits;
        req = '0;
        tick();
        u = 1'b0;
        total++; if (hits !== 4'(last_hits)) begin bad++; $display("FAIL hits_held got=%0d want=%0d", hits, last_hits); end
    endtask

    task automatic test_saturate;
        bit found;
        exp_t e;
        int ei;
        wdata = $urandom(); wdata2 = $urandom();
        req = 4'b0100; req2 = 4'b0001; u = 1'b1; u2 = 1'b1;
        ei = next_idx(rr_last, req);
        sbq.push_back('{ei, sat(WIDTH + DRAIN, CW)});
        tick();
        total++; if ({gnt2, busy2, linea2} !== {4'b0001, 1'b1, wdata2[0]}) begin
            bad++; $display("FAIL sat2_grant got=%b want=%b", {gnt2, busy2, linea2}, {4'b0001, 1'b1, wdata2[0]});
        end
        wait_done(20, found);
        total++; if (!found) begin bad++; $display("FAIL sat_timeout done never seen"); end
        total++; if (done2 !== 1'b1) begin bad++; $display("FAIL sat2_done got=%b want=1", done2); end
        total++; if (hits2 !== 2'(sat(WIDTH + DRAIN, 2))) begin bad++; $display("FAIL sat2_hits got=%0d want=%0d", hits2, sat(WIDTH + DRAIN, 2)); end
        e = sbq.pop_front();
        total++; if (gnt_idx(gnt) !== e.idx) begin bad++; $display("FAIL sat_sb_idx got=%0d want=%0d", gnt_idx(gnt), e.idx); end
        total++; if (hits !== 4'(e.hits)) begin bad++; $display("FAIL sat_sb_hits got=%0d want=%0d", hits, e.hits); end
        rr_last = e.idx; last_hits = e.hits;
        req = '0; req2 = '0; u = 1'b0; u2 = 1'b0;
        tick();
    endtask

    task automatic test_round_robin;
        exp_t e;
        int ei, ndone, multi;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rr_last = 3;
        req = 4'b1111; u = 1'b0;
        tick();
        for (int t = 0; t < 5; t++) begin
            ei = next_idx(rr_last, req);
            sbq.push_back('{ei, 0});
            total++; if (gnt !== 4'(1 << ei)) begin bad++; $display("FAIL rr%0d_gnt got=%b want=%b", t, gnt, 4'(1 << ei)); end
            ndone = 0; multi = 0;
            for (int c = 0; c < 11; c++) begin
                if (!$onehot(gnt)) multi++;
                if (done === 1'b1) ndone++;
                if (c < 10) tick();
            end
            total++; if (ndone !== 1 || done !== 1'b1) begin bad++; $display("FAIL rr%0d_done count=%0d last=%b want count=1 last=1", t, ndone, done); end
            total++; if (multi !== 0) begin bad++; $display("FAIL rr%0d_onehot bad_cycles=%0d want=0", t, multi); end
            e = sbq.pop_front();
            total++; if (gnt_idx(gnt) !== e.idx || hits !== 4'(e.hits)) begin
                bad++; $display("FAIL rr%0d_sb idx=%0d hits=%0d want idx=%0d hits=%0d", t, gnt_idx(gnt), hits, e.idx, e.hits);
            end
            rr_last = e.idx; last_hits = e.hits;
            if (t == 4) req = '0;
            tick();
        end
        total++; if (gnt !== 4'b0) begin bad++; $display("FAIL rr_end_gnt got=%b want=0000", gnt); end
    endtask

    task automatic test_fairness;
        bit found;
        exp_t e;
        int ei;
        wdata = $urandom();
        req = 4'b0100; u = 1'b1;
        ei = next_idx(rr_last, req);
        sbq.push_back('{ei, sat(WIDTH + DRAIN, CW)});
        tick();
        req = 4'b0110;
        for (int n = 0; n < 3; n++) begin
            total++; if (gnt !== 4'(1 << ei)) begin bad++; $display("FAIL fair%0d_gnt got=%b want=%b", n, gnt, 4'(1 << ei)); end
            wait_done(20, found);
            total++; if (!found) begin bad++; $display("FAIL fair%0d_timeout done never seen", n); end
            e = sbq.pop_front();
            total++; if (gnt_idx(gnt) !== e.idx || hits !== 4'(e.hits)) begin
                bad++; $display("FAIL fair%0d_sb idx=%0d hits=%0d want idx=%0d hits=%0d", n, gnt_idx(gnt), hits, e.idx, e.hits);
            end
            rr_last = e.idx; last_hits = e.hits;
            if (n == 2) begin
                req = '0;
            end else begin
                ei = next_idx(rr_last, req);
                sbq.push_back('{ei, sat(WIDTH + DRAIN, CW)});
            end
            tick();
        end
        u = 1'b0;
    endtask

    task automatic test_mid_reset;
        exp_t e;
        int ei;
        wdata = $urandom();
        req = 4'b0001; u = 1'b1;
        tick();
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        total++; if ({gnt, linea, busy, done} !== 7'b0) begin bad++; $display("FAIL midrst_outs got=%b want=0000000", {gnt, linea, busy, done}); end
        total++; if (hits !== 4'd0) begin bad++; $display("FAIL midrst_hits got=%0d want=0", hits); end
        reset = 1'b0;
        rr_last = 3;
        req = 4'b1000; u = 1'b0;
        ei = next_idx(rr_last, req);
        sbq.push_back('{ei, DRAIN});
        tick();
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL midrst_regrant got=%b want=1000", gnt); end
        for (int c = 0; c < WIDTH; c++) tick();
        u = 1'b1;
        for (int c = 0; c < DRAIN; c++) tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL midrst_done got=%b want=1", done); end
        e = sbq.pop_front();
        total++; if (gnt_idx(gnt) !== e.idx || hits !== 4'(e.hits)) begin
            bad++; $display("FAIL midrst_sb idx=%0d hits=%0d want idx=%0d hits=%0d", gnt_idx(gnt), hits, e.idx, e.hits);
        end
        rr_last = e.idx; last_hits = e.hits;
        u = 1'b0; req = '0;
        tick();
    endtask

    task automatic test_abort;
        int ei;
`ifndef LINE_SCHED_ABORT_EN
        bit found;
        exp_t e;
`endif
        wdata = $urandom();
        req = 4'b0001; u = 1'b1;
        ei = next_idx(rr_last, req);
`ifndef LINE_SCHED_ABORT_EN
        sbq.push_back('{ei, sat(WIDTH + DRAIN, CW)});
`endif
        tick();
        for (int c = 0; c < 5; c++) tick();
        req = '0;
`ifdef LINE_SCHED_ABORT_EN
        tick();
        total++; if ({gnt, linea, busy, done} !== 7'b0) begin bad++; $display("FAIL abort_outs got=%b want=0000000", {gnt, linea, busy, done}); end
        total++; if (hits !== 4'(last_hits)) begin bad++; $display("FAIL abort_hits got=%0d want=%0d", hits, last_hits); end
        rr_last = ei;
        u = 1'b0;
        tick();
        total++; if (gnt !== 4'b0) begin bad++; $display("FAIL abort_idle got=%b want=0000", gnt); end
`else
        wait_done(20, found);
        total++; if (!found) begin bad++; $display("FAIL abort_timeout done never seen"); end
        e = sbq.pop_front();
        total++; if (gnt_idx(gnt) !== e.idx || hits !== 4'(e.hits)) begin
            bad++; $display("FAIL abort_sb idx=%0d hits=%0d want idx=%0d hits=%0d", gnt_idx(gnt), hits, e.idx, e.hits);
        end
        rr_last = e.idx; last_hits = e.hits;
        u = 1'b0;
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_hits();
        test_saturate();
        test_round_robin();
        test_fairness();
        test_mid_reset();
        test_abort();
        total++; if (sbq.size() !== 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sbq.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
